// File: rtl/bram32_pkg.sv
// Shared definitions for the bram32 RAM and its two-port arbiter.
// Defines the write subaddress codes, the port enum and the byte-lane decode.
package bram32_pkg;

    localparam logic [2:0] SUB_NONE  = 3'd0;
    localparam logic [2:0] SUB_WORD  = 3'd1;
    localparam logic [2:0] SUB_HALF0 = 3'd2;
    localparam logic [2:0] SUB_HALF1 = 3'd3;
    localparam logic [2:0] SUB_BYTE0 = 3'd4;
    localparam logic [2:0] SUB_BYTE1 = 3'd5;
    localparam logic [2:0] SUB_BYTE2 = 3'd6;
    localparam logic [2:0] SUB_BYTE3 = 3'd7;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // Byte-lane write enables for a subaddress code; bit n enables data[8n+7:8n].
    function automatic logic [3:0] sub_lane_mask(input logic [2:0] sub);
        logic [3:0] mask;
        case (sub)
            SUB_WORD:  mask = 4'b1111;
            SUB_HALF0: mask = 4'b0011;
            SUB_HALF1: mask = 4'b1100;
            SUB_BYTE0: mask = 4'b0001;
            SUB_BYTE1: mask = 4'b0010;
            SUB_BYTE2: mask = 4'b0100;
            SUB_BYTE3: mask = 4'b1000;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bram32.sv
// Single-port 32-bit RAM with byte-lane writes; registered read data, 1 cycle.
// No backpressure: one access per cycle, read returns the pre-write contents.
module bram32
    import bram32_pkg::*;
#(
    parameter  int DEPTH      = 512,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_data,
    input  logic                  i_we,
    input  logic [2:0]            i_wr_subaddr,
    output logic [31:0]           o_data
);

    logic [31:0] mem [DEPTH];
    logic [3:0]  lane_en;

    always_comb begin
        lane_en = i_we ? sub_lane_mask(i_wr_subaddr) : 4'b0000;
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) begin
                mem[i_addr][8*b +: 8] <= i_data[8*b +: 8];
            end
        end
        o_data <= mem[i_addr];
    end

endmodule

// File: rtl/bram32_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; combinational grant, last-grant register.
// On a tie the requester not granted most recently wins; reset favours port I.
module rr_arb2
    import bram32_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output port_e      last
);

    port_e r_last;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (r_last == PORT_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= PORT_D;
        end else if (gnt != 2'b00) begin
            r_last <= gnt[1] ? PORT_D : PORT_I;
        end
    end

    assign last = r_last;

endmodule

// File: rtl/bram32_arbiter.sv
// Shares one bram32 between a fetch port and a data port, one op per cycle.
// Ack exactly one cycle after grant; a losing requester simply holds req.
module bram32_arbiter
    import bram32_pkg::*;
#(
    parameter  int DEPTH      = 512,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_i_req,
    input  logic [ADDR_WIDTH-1:0] i_i_addr,
    output logic                  o_i_ack,
    output logic [31:0]           o_i_rdata,
    input  logic                  i_d_req,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic                  i_d_we,
    input  logic [31:0]           i_d_wdata,
    input  logic [2:0]            i_d_wr_subaddr,
    output logic                  o_d_ack,
    output logic [31:0]           o_d_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_data,
    output logic                  o_mem_we,
    output logic [2:0]            o_mem_wr_subaddr,
    input  logic [31:0]           i_mem_rdata
);

    logic       r_busy_i;
    logic       r_busy_d;
    logic [1:0] eligible;
    logic [1:0] gnt;
    port_e      last_port;

    // A port in its ack cycle is masked so a held req is not granted twice.
    assign eligible = {i_d_req & ~r_busy_d, i_i_req & ~r_busy_i};

    rr_arb2 u_rr_arb2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .req     (eligible),
        .gnt     (gnt),
        .last    (last_port)
    );

    always_comb begin
        o_mem_addr       = '0;
        o_mem_data       = 32'h0;
        o_mem_we         = 1'b0;
        o_mem_wr_subaddr = SUB_NONE;
        if (gnt[0]) begin
            o_mem_addr = i_i_addr;
        end else if (gnt[1]) begin
            o_mem_addr       = i_d_addr;
            o_mem_data       = i_d_wdata;
            o_mem_we         = i_d_we & (i_d_wr_subaddr != SUB_NONE);
            o_mem_wr_subaddr = i_d_wr_subaddr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy_i <= 1'b0;
            r_busy_d <= 1'b0;
        end else begin
            r_busy_i <= gnt[0];
            r_busy_d <= gnt[1];
        end
    end

    assign o_i_ack   = r_busy_i;
    assign o_d_ack   = r_busy_d;
    assign o_i_rdata = i_mem_rdata;
    assign o_d_rdata = i_mem_rdata;

    logic unused_last;
    assign unused_last = last_port;

endmodule

// File: tb/tb_bram32_arbiter.sv
// Scoreboarded bench: bram32_arbiter in front of a 512-word bram32.
module tb_bram32_arbiter;
    import bram32_pkg::*;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [31:0]   d_wdata;
    logic [2:0]    d_sub;
    logic          i_ack, d_ack;
    logic [31:0]   i_rdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data, mem_rdata;
    logic          mem_we;
    logic [2:0]    mem_sub;

    always #5 clk = ~clk;

    bram32_arbiter #(.DEPTH(512)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_i_req(i_req), .i_i_addr(i_addr), .o_i_ack(i_ack), .o_i_rdata(i_rdata),
        .i_d_req(d_req), .i_d_addr(d_addr), .i_d_we(d_we), .i_d_wdata(d_wdata),
        .i_d_wr_subaddr(d_sub), .o_d_ack(d_ack), .o_d_rdata(d_rdata),
        .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_mem_we(mem_we),
        .o_mem_wr_subaddr(mem_sub), .i_mem_rdata(mem_rdata)
    );

    bram32 #(.DEPTH(512)) u_ram (
        .i_clk(clk), .i_addr(mem_addr), .i_data(mem_data), .i_we(mem_we),
        .i_wr_subaddr(mem_sub), .o_data(mem_rdata)
    );

    typedef struct { bit chk_data; logic [31:0] data; } exp_t;
    typedef struct { bit port; int cyc; } ack_t;

    exp_t q_i[$];
    exp_t q_d[$];
    ack_t hist[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   prev_idle = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the per-port expectation on every ack, checks idle rules every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            bit idle_now;
            exp_t e;
            idle_now = !i_req && !d_req;
            if (i_ack) begin
                hist.push_back('{1'b0, cyc});
                if (q_i.size() == 0) chk("i_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = q_i.pop_front();
                    if (e.chk_data) chk("i_rdata", i_rdata, e.data);
                end
            end
            if (d_ack) begin
                hist.push_back('{1'b1, cyc});
                if (q_d.size() == 0) chk("d_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = q_d.pop_front();
                    if (e.chk_data) chk("d_rdata", d_rdata, e.data);
                end
            end
            checks++;
            assert (!(i_ack && d_ack)) else begin
                failures++;
                $display("FAIL both_acks actual=%0d%0d required=not both", i_ack, d_ack);
            end
            if (idle_now) begin
                checks++;
                assert (!mem_we && mem_addr == '0) else begin
                    failures++;
                    $display("FAIL idle_mem actual we=%0d addr=%0d required we=0 addr=0", mem_we, mem_addr);
                end
                if (prev_idle) begin
                    checks++;
                    assert (!i_ack && !d_ack) else begin
                        failures++;
                        $display("FAIL idle_ack actual=%0d%0d required=00", i_ack, d_ack);
                    end
                end
            end
            prev_idle = idle_now;
        end
    end

    task automatic d_op(input logic [AW-1:0] a, input logic we, input logic [31:0] wd,
                        input logic [2:0] sub, input bit chkd, input logic [31:0] exp,
                        input string nm);
        int lat;
        bit got;
        q_d.push_back('{chkd, exp});
        @(posedge clk); #1;
        d_req = 1; d_addr = a; d_we = we; d_wdata = wd; d_sub = sub;
        lat = 0; got = 0;
        while (!got && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (d_ack) got = 1;
        end
        d_req = 0; d_we = 0;
        chk({nm, "_lat"}, lat, 1);
    endtask

    task automatic rst_pulse();
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
    endtask

    initial begin
        int c0;
        rst_n = 0; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_sub = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        mon_en = 1;

        d_op(9'd5, 1, 32'hDEADBEEF, SUB_WORD, 0, 0, "wr_word");
        d_op(9'd5, 0, 32'h0, SUB_NONE, 1, 32'hDEADBEEF, "rd_word");
        d_op(9'd5, 1, 32'h00AA0000, SUB_BYTE2, 0, 0, "wr_byte2");
        d_op(9'd5, 0, 32'h0, SUB_NONE, 1, 32'hDEAABEEF, "rd_byte2");
        d_op(9'd5, 1, 32'hFFFFFFFF, SUB_NONE, 0, 0, "wr_sub0");
        d_op(9'd5, 0, 32'h0, SUB_NONE, 1, 32'hDEAABEEF, "rd_sub0");
        d_op(9'd1, 1, 32'h00000011, SUB_WORD, 0, 0, "wr_addr1");

        // Both ports held 8 cycles: I,D,I,D... one ack per cycle.
        rst_pulse();
        for (int k = 0; k < 4; k++) begin
            q_i.push_back('{1'b1, 32'h11});
            q_d.push_back('{1'b1, 32'hDEAABEEF});
        end
        hist.delete();
        @(posedge clk); #1;
        c0 = cyc;
        i_req = 1; i_addr = 9'd1;
        d_req = 1; d_addr = 9'd5; d_we = 0;
        repeat (8) @(posedge clk);
        #1 i_req = 0; d_req = 0;
        repeat (3) @(posedge clk);
        #1 chk("dual_ack_count", hist.size(), 8);
        for (int k = 0; k < hist.size() && k < 8; k++) begin
            chk($sformatf("dual_port_%0d", k), hist[k].port, k % 2);
            chk($sformatf("dual_cyc_%0d", k), hist[k].cyc, c0 + 1 + k);
        end

        // Only I held 6 cycles: ack every other cycle.
        for (int k = 0; k < 3; k++) q_i.push_back('{1'b1, 32'h11});
        hist.delete();
        @(posedge clk); #1;
        c0 = cyc;
        i_req = 1; i_addr = 9'd1;
        repeat (6) @(posedge clk);
        #1 i_req = 0;
        repeat (3) @(posedge clk);
        #1 chk("ionly_ack_count", hist.size(), 3);
        for (int k = 0; k < hist.size() && k < 3; k++) begin
            chk($sformatf("ionly_port_%0d", k), hist[k].port, 0);
            chk($sformatf("ionly_cyc_%0d", k), hist[k].cyc, c0 + 1 + 2 * k);
        end

        // Reset in the grant cycle of a D write: no ack afterwards.
        hist.delete();
        @(posedge clk); #1;
        rst_n = 0;
        d_req = 1; d_addr = 9'd7; d_we = 1; d_wdata = 32'h12345678; d_sub = SUB_WORD;
        @(posedge clk); #1;
        rst_n = 1; d_req = 0; d_we = 0;
        repeat (3) @(posedge clk);
        #1 chk("rst_drop_acks", hist.size(), 0);
        d_op(9'd1, 0, 32'h0, SUB_NONE, 1, 32'h11, "post_rst_rd");

        repeat (3) @(posedge clk);
        #1;
        chk("q_i_empty", q_i.size(), 0);
        chk("q_d_empty", q_d.size(), 0);
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
